easyaxi_rd_mst: RTL

- AXI read traffic master that sits directly upstream of EASYAXI_SLV and drives its AR channel and R channel.
- On a start pulse it issues a programmed number of read bursts, keeping up to OST_DEPTH of them outstanding.
- It tracks the expected ID and beat count for every outstanding burst in an in-order FIFO.
- It checks each returned R beat against that FIFO and accumulates error and response statistics for the testbench or a status register.

---
 rtl/easyaxi_rd_mst_pkg.sv | 47 ++++
 rtl/easyaxi_ost_fifo.sv | 59 +++++
 rtl/easyaxi_rd_mst.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/easyaxi_rd_mst_pkg.sv
`default_nettype none
// ============================================================================
// Module      : easyaxi_rd_mst_pkg
// Description : Shared AXI width/response defines and the read-master package
//               (FSM state type, FIFO entry width and the burst stride helper).
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef EASYAXI_DEFINE_SVH
`define EASYAXI_DEFINE_SVH
`define AXI_ID_W        4
`define AXI_ADDR_W      32
`define AXI_LEN_W       8
`define AXI_SIZE_W      3
`define AXI_BURST_W     2
`define AXI_DATA_W      64
`define AXI_RESP_W      2
`define AXI_RESP_OKAY   2'b00
`define AXI_RESP_SLVERR 2'b10
`define AXI_RESP_DECERR 2'b11
`endif

package easyaxi_rd_mst_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_e;

    // One FIFO entry is {id, len} of an outstanding burst.
    localparam int c_FIFO_W = `AXI_ID_W + `AXI_LEN_W;

    // Bytes spanned by one burst: (len + 1) << size, in address width.
    function automatic logic [`AXI_ADDR_W-1:0] f_burst_bytes(
        input logic [`AXI_LEN_W-1:0]  len,
        input logic [`AXI_SIZE_W-1:0] size
    );
        logic [`AXI_ADDR_W-1:0] v_beats;
        v_beats = `AXI_ADDR_W'(len) + `AXI_ADDR_W'(1);
        return v_beats << size;
    endfunction

endpackage

`default_nettype wire

// File: rtl/easyaxi_ost_fifo.sv
`default_nettype none
// ============================================================================
// Module      : easyaxi_ost_fifo
// Description : Synchronous FIFO holding outstanding-burst descriptors.
//               dout shows the head entry combinationally. A push and a pop
//               in the same cycle are accepted even when the FIFO is full.
// Ports       : clk, rst (async, active-high), push, pop, din, dout,
//               empty, full
// Revision    : 1.0 - initial release
// ============================================================================

module easyaxi_ost_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [c_PTR_W:0]   r_wr_ptr;
    logic [c_PTR_W:0]   r_rd_ptr;
    logic               w_do_push;
    logic               w_do_pop;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                       (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
    assign w_do_pop  = pop && !empty;
    // When full, the slot freed by a simultaneous pop is the one written.
    assign w_do_push = push && (!full || w_do_pop);
    assign dout      = r_mem[r_rd_ptr[c_PTR_W-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_PTR_W-1:0]] <= din;
    end

endmodule

`default_nettype wire

// File: rtl/easyaxi_rd_mst.sv
`default_nettype none
// ============================================================================
// Module      : easyaxi_rd_mst
// Description : AXI read traffic master. On start it issues cfg_num_req read
//               bursts with up to OST_DEPTH outstanding, tracks {id, len} of
//               each in an in-order FIFO and checks every returned R beat,
//               accumulating saturating error/response statistics.
// Ports       : clk, rst (async, active-high)
//               start, cfg_*          - launch pulse and burst configuration
//               busy, done            - status (done is a one-cycle pulse)
//               *_err_cnt, unexp_cnt  - statistics
//               axi_mst_ar*, axi_mst_r* - AXI AR and R channels
// Revision    : 1.0 - initial release
// ============================================================================

module easyaxi_rd_mst
    import easyaxi_rd_mst_pkg::*;
#(
    parameter int OST_DEPTH = 8,
    parameter int CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [CNT_W-1:0]         cfg_num_req,
    input  logic [`AXI_ADDR_W-1:0]   cfg_base_addr,
    input  logic [`AXI_LEN_W-1:0]    cfg_len,
    input  logic [`AXI_SIZE_W-1:0]   cfg_size,
    input  logic [`AXI_BURST_W-1:0]  cfg_burst,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         id_err_cnt,
    output logic [CNT_W-1:0]         last_err_cnt,
    output logic [CNT_W-1:0]         unexp_cnt,
    output logic [CNT_W-1:0]         resp_err_cnt,
    output logic                     axi_mst_arvalid,
    input  logic                     axi_mst_arready,
    output logic [`AXI_ID_W-1:0]     axi_mst_arid,
    output logic [`AXI_ADDR_W-1:0]   axi_mst_araddr,
    output logic [`AXI_LEN_W-1:0]    axi_mst_arlen,
    output logic [`AXI_SIZE_W-1:0]   axi_mst_arsize,
    output logic [`AXI_BURST_W-1:0]  axi_mst_arburst,
    input  logic                     axi_mst_rvalid,
    output logic                     axi_mst_rready,
    input  logic [`AXI_ID_W-1:0]     axi_mst_rid,
    input  logic [`AXI_DATA_W-1:0]   axi_mst_rdata,
    input  logic [`AXI_RESP_W-1:0]   axi_mst_rresp,
    input  logic                     axi_mst_rlast
);

    localparam int c_OST_W = $clog2(OST_DEPTH) + 1;

    rd_state_e                  r_state;
    logic                       r_busy;
    logic                       r_done;
    logic [CNT_W-1:0]           r_num_req;
    logic [CNT_W-1:0]           r_req_cnt;
    logic [`AXI_ADDR_W-1:0]     r_araddr;
    logic [`AXI_ADDR_W-1:0]     r_stride;
    logic [`AXI_LEN_W-1:0]      r_len;
    logic [`AXI_SIZE_W-1:0]     r_size;
    logic [`AXI_BURST_W-1:0]    r_burst;
    logic [c_OST_W-1:0]         r_ost_cnt;
    logic [`AXI_LEN_W-1:0]      r_beat_cnt;
    logic [CNT_W-1:0]           r_id_err_cnt;
    logic [CNT_W-1:0]           r_last_err_cnt;
    logic [CNT_W-1:0]           r_unexp_cnt;
    logic [CNT_W-1:0]           r_resp_err_cnt;

    logic                       w_launch;
    logic                       w_arvalid;
    logic                       w_ar_hs;
    logic                       w_r_hs;
    logic                       w_beat_chk;
    logic                       w_pop;
    logic                       w_empty;
    logic                       w_full;
    logic [c_FIFO_W-1:0]        w_head;
    logic [`AXI_ID_W-1:0]       w_head_id;
    logic [`AXI_LEN_W-1:0]      w_head_len;
    logic                       w_unused_rdata;

    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Read data is accepted without checking.
    assign w_unused_rdata = ^axi_mst_rdata;

    assign w_launch   = (r_state == ST_IDLE) && start;
    // arvalid is built only from registered state, so it cannot drop before
    // arready: req_cnt moves only on a handshake and ost_cnt only falls.
    assign w_arvalid  = (r_state == ST_ISSUE) && (r_req_cnt < r_num_req) &&
                        (r_ost_cnt < c_OST_W'(OST_DEPTH));
    assign w_ar_hs    = w_arvalid && axi_mst_arready;
    assign w_r_hs     = axi_mst_rvalid && r_busy;
    assign w_beat_chk = w_r_hs && !w_empty;
    assign w_pop      = w_beat_chk && axi_mst_rlast;
    assign {w_head_id, w_head_len} = w_head;

    easyaxi_ost_fifo #(
        .WIDTH (c_FIFO_W),
        .DEPTH (OST_DEPTH)
    ) u_ost_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_ar_hs),
        .pop   (w_pop),
        .din   ({axi_mst_arid, r_len}),
        .dout  (w_head),
        .empty (w_empty),
        .full  (w_full)
    );

    // Control FSM plus the AR request state it owns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_num_req <= '0;
            r_req_cnt <= '0;
            r_araddr  <= '0;
            r_stride  <= '0;
            r_len     <= '0;
            r_size    <= '0;
            r_burst   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state   <= ST_ISSUE;
                        r_busy    <= 1'b1;
                        r_num_req <= cfg_num_req;
                        r_req_cnt <= '0;
                        r_araddr  <= cfg_base_addr;
                        r_stride  <= f_burst_bytes(cfg_len, cfg_size);
                        r_len     <= cfg_len;
                        r_size    <= cfg_size;
                        r_burst   <= cfg_burst;
                    end
                end
                ST_ISSUE: begin
                    if (w_ar_hs) begin
                        r_req_cnt <= r_req_cnt + CNT_W'(1);
                        // Running sum equals base + req_cnt * stride.
                        r_araddr  <= r_araddr + r_stride;
                    end
                    if (r_req_cnt == r_num_req) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (r_ost_cnt == '0) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Outstanding count, beat tracking and statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ost_cnt      <= '0;
            r_beat_cnt     <= '0;
            r_id_err_cnt   <= '0;
            r_last_err_cnt <= '0;
            r_unexp_cnt    <= '0;
            r_resp_err_cnt <= '0;
        end else begin
            case ({w_ar_hs, w_pop})
                2'b10:   r_ost_cnt <= r_ost_cnt + c_OST_W'(1);
                2'b01:   r_ost_cnt <= r_ost_cnt - c_OST_W'(1);
                default: r_ost_cnt <= r_ost_cnt;
            endcase

            if (w_launch) begin
                r_id_err_cnt   <= '0;
                r_last_err_cnt <= '0;
                r_unexp_cnt    <= '0;
                r_resp_err_cnt <= '0;
            end else if (w_beat_chk) begin
                if (axi_mst_rid != w_head_id) begin
                    r_id_err_cnt <= f_sat_inc(r_id_err_cnt);
                end
                if (axi_mst_rlast != (r_beat_cnt == w_head_len)) begin
                    r_last_err_cnt <= f_sat_inc(r_last_err_cnt);
                end
                if (axi_mst_rresp != `AXI_RESP_OKAY) begin
                    r_resp_err_cnt <= f_sat_inc(r_resp_err_cnt);
                end
            end else if (w_r_hs) begin
                r_unexp_cnt <= f_sat_inc(r_unexp_cnt);
            end

            if (w_beat_chk) begin
                r_beat_cnt <= axi_mst_rlast ? '0 : r_beat_cnt + `AXI_LEN_W'(1);
            end
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign id_err_cnt      = r_id_err_cnt;
    assign last_err_cnt    = r_last_err_cnt;
    assign unexp_cnt       = r_unexp_cnt;
    assign resp_err_cnt    = r_resp_err_cnt;
    assign axi_mst_arvalid = w_arvalid;
    assign axi_mst_arid    = r_req_cnt[`AXI_ID_W-1:0];
    assign axi_mst_araddr  = r_araddr;
    assign axi_mst_arlen   = r_len;
    assign axi_mst_arsize  = r_size;
    assign axi_mst_arburst = r_burst;
    assign axi_mst_rready  = r_busy;

endmodule

`default_nettype wire
